// File: rtl/fetch_issue_queue_pkg.sv
// Shared decode constants and fetch FSM state encoding for the fetch/issue front end.
package fetch_issue_queue_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    localparam logic [2:0] C_F3_JAL  = 3'b001;
    localparam logic [2:0] C_F3_JR   = 3'b100;
    localparam logic [2:0] C_F3_J    = 3'b101;
    localparam logic [2:0] C_F3_BEQZ = 3'b110;
    localparam logic [2:0] C_F3_BNEZ = 3'b111;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_STALL
    } fetch_state_e;

endpackage

// File: rtl/fetch_issue_queue_predictor.sv
// Static next-PC prediction: direct jumps taken, branches BTFN, indirect jumps flagged for stall.
module next_pc_predictor #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       ins,
    output logic [ADDR_W-1:0] pred_pc,
    output logic              is_rvc,
    output logic              is_jalr_class
);
    import fetch_issue_queue_pkg::*;

    logic signed [20:0] imm_j;
    logic signed [12:0] imm_b;
    logic signed [11:0] imm_cj;
    logic signed [8:0]  imm_cb;
    logic [2:0]         c_f3;

    assign imm_j  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    assign imm_b  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_cj = {ins[12], ins[8], ins[10:9], ins[6], ins[7], ins[2], ins[11], ins[5:3], 1'b0};
    assign imm_cb = {ins[12], ins[6:5], ins[2], ins[11:10], ins[4:3], 1'b0};
    assign c_f3   = ins[15:13];

    always_comb begin
        is_rvc        = (ins[1:0] != 2'b11);
        is_jalr_class = 1'b0;
        pred_pc       = pc + (is_rvc ? ADDR_W'(2) : ADDR_W'(4));
        if (!is_rvc) begin
            case (ins[6:0])
                OP_JAL:    pred_pc = pc + ADDR_W'(imm_j);
                OP_BRANCH: if (imm_b[12]) pred_pc = pc + ADDR_W'(imm_b);
                OP_JALR:   is_jalr_class = 1'b1;
                default:   ;
            endcase
        end else if (ins[1:0] == RVC_Q1 && (c_f3 == C_F3_J || c_f3 == C_F3_JAL)) begin
            pred_pc = pc + ADDR_W'(imm_cj);
        end else if (ins[1:0] == RVC_Q1 && (c_f3 == C_F3_BEQZ || c_f3 == C_F3_BNEZ)) begin
            if (imm_cb[8]) pred_pc = pc + ADDR_W'(imm_cb);
        end else if (ins[1:0] == RVC_Q2 && c_f3 == C_F3_JR && ins[11:7] != 5'd0 && ins[6:2] == 5'd0) begin
            is_jalr_class = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_issue_queue.sv
// Fetch front end: one outstanding I-cache request, static next-PC prediction, and an issue FIFO.
module fetch_issue_queue #(
    parameter int                ADDR_W      = 32,
    parameter int                QUEUE_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           flush_pipeline,
    input  logic [ADDR_W-1:0]              reset_pc_to,
    input  logic                           jalr_done,
    input  logic [ADDR_W-1:0]              jalr_target,
    output logic                           icache_req,
    output logic [ADDR_W-1:0]              icache_addr,
    input  logic                           icache_ready,
    input  logic [31:0]                    icache_data,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [ADDR_W-1:0]              issue_pc,
    output logic [31:0]                    issue_ins,
    output logic [ADDR_W-1:0]              issue_pred_pc,
    output logic                           issue_is_compressed,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);
    import fetch_issue_queue_pkg::*;

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    fetch_state_e      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, addr_n;
    logic              req_n, push, pop;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;

    logic [QUEUE_DEPTH-1:0][ADDR_W-1:0] q_pc, q_pred;
    logic [QUEUE_DEPTH-1:0][31:0]       q_ins;
    logic [QUEUE_DEPTH-1:0]             q_rvc;

    logic [ADDR_W-1:0] pred_pc;
    logic              is_rvc, is_jalr_class;

    // The word being returned always belongs to pc: pc only moves on accept or redirect.
    next_pc_predictor #(.ADDR_W(ADDR_W)) u_pred (
        .pc            (pc),
        .ins           (icache_data),
        .pred_pc       (pred_pc),
        .is_rvc        (is_rvc),
        .is_jalr_class (is_jalr_class)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      state <= FETCH_IDLE;
        else if (rdy_in) state <= state_n;
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = icache_req;
        addr_n  = icache_addr;
        push    = 1'b0;
        if (flush_pipeline) begin
            state_n = FETCH_IDLE;
            pc_n    = reset_pc_to;
            req_n   = 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: if (count < CW'(QUEUE_DEPTH)) begin
                    state_n = FETCH_WAIT;
                    req_n   = 1'b1;
                    addr_n  = pc;
                end
                FETCH_WAIT: if (icache_ready) begin
                    push    = 1'b1;
                    pc_n    = pred_pc;
                    req_n   = 1'b0;
                    state_n = is_jalr_class ? FETCH_STALL : FETCH_IDLE;
                end
                FETCH_STALL: if (jalr_done) begin
                    pc_n    = jalr_target;
                    state_n = FETCH_IDLE;
                end
                default: state_n = FETCH_IDLE;
            endcase
        end
    end

    assign pop = issue_valid && issue_ready && !flush_pipeline;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc          <= RESET_PC;
            icache_req  <= 1'b0;
            icache_addr <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            q_pc        <= '0;
            q_pred      <= '0;
            q_ins       <= '0;
            q_rvc       <= '0;
        end else if (rdy_in) begin
            pc          <= pc_n;
            icache_req  <= req_n;
            icache_addr <= addr_n;
            if (flush_pipeline) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    q_pc[wr_ptr]   <= pc;
                    q_ins[wr_ptr]  <= icache_data;
                    q_pred[wr_ptr] <= pred_pc;
                    q_rvc[wr_ptr]  <= is_rvc;
                    wr_ptr         <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    assign issue_valid         = (count != '0);
    assign issue_pc            = q_pc[rd_ptr];
    assign issue_ins           = q_ins[rd_ptr];
    assign issue_pred_pc       = q_pred[rd_ptr];
    assign issue_is_compressed = q_rvc[rd_ptr];
    assign queue_count         = count;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench for fetch_issue_queue with an I-cache model and an issue-order scoreboard.
module tb_fetch_issue_queue;

    localparam logic [31:0] INS_ADDI   = 32'h00108093;
    localparam logic [31:0] INS_BEQ_M8 = 32'hFE000CE3;
    localparam logic [31:0] INS_BEQ_P8 = 32'h00000463;
    localparam logic [31:0] INS_C_ADDI = 32'h00000085;
    localparam logic [31:0] INS_C_J6   = 32'h0000A019;
    localparam logic [31:0] INS_JALR   = 32'h00008067;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pred;
        logic        rvc;
    } mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pred;
        logic        rvc;
    } sb_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_pipeline, jalr_done, icache_ready, issue_ready;
    logic [31:0] reset_pc_to, jalr_target, icache_data;
    logic        icache_req, issue_valid, issue_is_compressed;
    logic [31:0] icache_addr, issue_pc, issue_ins, issue_pred_pc;
    logic [2:0]  queue_count;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_fetch;
    bit          jalr_seen;
    sb_t         sb[$];
    mem_t        mem[logic [31:0]];

    fetch_issue_queue dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .flush_pipeline      (flush_pipeline),
        .reset_pc_to         (reset_pc_to),
        .jalr_done           (jalr_done),
        .jalr_target         (jalr_target),
        .icache_req          (icache_req),
        .icache_addr         (icache_addr),
        .icache_ready        (icache_ready),
        .icache_data         (icache_data),
        .issue_valid         (issue_valid),
        .issue_ready         (issue_ready),
        .issue_pc            (issue_pc),
        .issue_ins           (issue_ins),
        .issue_pred_pc       (issue_pred_pc),
        .issue_is_compressed (issue_is_compressed),
        .queue_count         (queue_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic mem_t fetch_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return '{INS_ADDI, a + 32'd4, 1'b0};
    endfunction

    task automatic wait_head(input logic [31:0] a, input logic [31:0] pred, input logic rvc, input string tag);
        for (int i = 0; i < 60; i++) begin
            if (issue_valid && issue_pc == a) break;
            step();
        end
        chk({tag, "_seen"}, 64'(issue_valid && issue_pc == a), 64'd1);
        chk({tag, "_pred"}, 64'(issue_pred_pc), 64'(pred));
        chk({tag, "_rvc"}, 64'(issue_is_compressed), 64'(rvc));
    endtask

    // I-cache answers in the same cycle the request is seen; the scoreboard tracks accepted fetches.
    always @(negedge clk_in) begin
        if (rst_in) begin
            icache_ready = 1'b0;
        end else begin
            if (rdy_in && !flush_pipeline && issue_valid && issue_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_issue", 64'(issue_pc), 64'hFFFF_FFFF);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_pc",   64'(issue_pc),            64'(e.pc));
                    chk("sb_ins",  64'(issue_ins),           64'(e.ins));
                    chk("sb_pred", 64'(issue_pred_pc),       64'(e.pred));
                    chk("sb_rvc",  64'(issue_is_compressed), 64'(e.rvc));
                end
            end
            if (icache_req) begin
                mem_t m;
                m = fetch_mem(icache_addr);
                icache_ready = 1'b1;
                icache_data  = m.ins;
                if (rdy_in && !flush_pipeline) begin
                    chk("fetch_addr", 64'(icache_addr), 64'(exp_fetch));
                    sb.push_back('{icache_addr, m.ins, m.pred, m.rvc});
                    exp_fetch = m.pred;
                    if (icache_addr == 32'h30) jalr_seen = 1'b1;
                end
            end else begin
                icache_ready = 1'b0;
                icache_data  = '0;
            end
        end
    end

    initial begin
        logic [2:0]  f_cnt;
        logic        f_req;
        logic [31:0] f_addr, f_pc;
        rst_in = 1'b1; rdy_in = 1'b1; flush_pipeline = 1'b0; reset_pc_to = '0;
        jalr_done = 1'b0; jalr_target = '0; issue_ready = 1'b0;
        icache_ready = 1'b0; icache_data = '0;
        exp_fetch = '0; jalr_seen = 1'b0;
        mem[32'h10] = '{INS_BEQ_M8, 32'h08, 1'b0};

        step();
        chk("rst_req",   64'(icache_req),  64'd0);
        chk("rst_addr",  64'(icache_addr), 64'd0);
        chk("rst_valid", 64'(issue_valid), 64'd0);
        chk("rst_count", 64'(queue_count), 64'd0);
        chk("rst_pc",    64'(issue_pc),    64'd0);
        rst_in = 1'b0;

        // straight line fill with consumer stalled
        for (int i = 0; i < 60; i++) begin
            if (queue_count == 3'd4) break;
            step();
        end
        chk("fill_count", 64'(queue_count), 64'd4);
        chk("fill_head_pc", 64'(issue_pc), 64'h0);
        chk("fill_head_pred", 64'(issue_pred_pc), 64'h4);
        repeat (5) begin
            step();
            chk("full_req_low", 64'(icache_req), 64'd0);
            chk("full_count", 64'(queue_count), 64'd4);
        end
        issue_ready = 1'b1;
        wait_head(32'h10, 32'h08, 1'b0, "beq_back");
        repeat (10) step();

        // forward branch, RVC and JALR region
        flush_pipeline = 1'b1; reset_pc_to = 32'h10; exp_fetch = 32'h10; sb.delete();
        mem[32'h10] = '{INS_BEQ_P8, 32'h14, 1'b0};
        mem[32'h20] = '{INS_C_ADDI, 32'h22, 1'b1};
        mem[32'h22] = '{INS_C_J6, 32'h28, 1'b1};
        mem[32'h30] = '{INS_JALR, 32'h34, 1'b0};
        step();
        flush_pipeline = 1'b0;
        chk("flush1_count", 64'(queue_count), 64'd0);
        chk("flush1_req", 64'(icache_req), 64'd0);
        jalr_done = 1'b1; jalr_target = 32'h300;
        step();
        jalr_done = 1'b0;
        wait_head(32'h10, 32'h14, 1'b0, "beq_fwd");
        wait_head(32'h20, 32'h22, 1'b1, "c_addi");
        wait_head(32'h22, 32'h28, 1'b1, "c_j");

        for (int i = 0; i < 60; i++) begin
            if (jalr_seen) break;
            step();
        end
        chk("jalr_fetched", 64'(jalr_seen), 64'd1);
        step();
        repeat (5) begin
            step();
            chk("stall_req_low", 64'(icache_req), 64'd0);
        end
        jalr_done = 1'b1; jalr_target = 32'h100; exp_fetch = 32'h100;
        step();
        jalr_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (icache_req) break;
            step();
        end
        chk("jalr_resume_req", 64'(icache_req), 64'd1);
        chk("jalr_resume_addr", 64'(icache_addr), 64'h100);

        // flush with three entries and a response landing in the flush cycle
        issue_ready = 1'b0;
        flush_pipeline = 1'b1; reset_pc_to = 32'h180; exp_fetch = 32'h180; sb.delete();
        step();
        flush_pipeline = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (queue_count == 3'd3 && icache_req) break;
            step();
        end
        chk("pre_flush_state", 64'(queue_count == 3'd3 && icache_req), 64'd1);
        flush_pipeline = 1'b1; reset_pc_to = 32'h200; exp_fetch = 32'h200; sb.delete();
        step();
        flush_pipeline = 1'b0;
        chk("flush2_count", 64'(queue_count), 64'd0);
        chk("flush2_valid", 64'(issue_valid), 64'd0);
        chk("flush2_req", 64'(icache_req), 64'd0);
        for (int i = 0; i < 10; i++) begin
            if (icache_req) break;
            step();
        end
        chk("flush2_addr", 64'(icache_addr), 64'h200);

        // asynchronous reset while a request is outstanding
        for (int i = 0; i < 10; i++) begin
            if (icache_req) break;
            step();
        end
        rst_in = 1'b1; sb.delete(); exp_fetch = 32'h0;
        #1;
        chk("async_rst_req", 64'(icache_req), 64'd0);
        chk("async_rst_count", 64'(queue_count), 64'd0);
        chk("async_rst_valid", 64'(issue_valid), 64'd0);
        chk("async_rst_addr", 64'(icache_addr), 64'd0);
        step(); step();
        rst_in = 1'b0;

        // global enable low freezes everything, including a pending pop and response
        for (int i = 0; i < 60; i++) begin
            if (queue_count >= 3'd2 && icache_req) break;
            step();
        end
        chk("pre_freeze_state", 64'(queue_count >= 3'd2 && icache_req), 64'd1);
        rdy_in = 1'b0; issue_ready = 1'b1;
        f_cnt = queue_count; f_req = icache_req; f_addr = icache_addr; f_pc = issue_pc;
        repeat (5) begin
            step();
            chk("freeze_count", 64'(queue_count), 64'(f_cnt));
            chk("freeze_req", 64'(icache_req), 64'(f_req));
            chk("freeze_addr", 64'(icache_addr), 64'(f_addr));
            chk("freeze_head", 64'(issue_pc), 64'(f_pc));
        end
        rdy_in = 1'b1;
        repeat (30) step();
        chk("final_sb_drained", 64'(sb.size() <= 1), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
